// File: rtl/line_mem_scheduler.sv
// line_mem_scheduler: shares one 256-bit burst memory port between the I-cache
// and the D-cache. Round-robin arbitration, a one-entry posted writeback buffer
// with read forwarding, and drains taken when the memory port would otherwise idle.
module line_mem_scheduler #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LINE_W   = 256,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] imem_address,
    input  logic              imem_read,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,

    input  logic [ADDR_W-1:0] dmem_address,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,

    output logic [ADDR_W-1:0] bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [LINE_W-1:0] bmem_wdata,
    input  logic [LINE_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    localparam int unsigned OFF = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {IDLE, IRD, DRD, FWD, DACK, DRAIN} state_t;
    typedef enum logic {SRC_I, SRC_D} src_t;

    state_t            state;
    src_t              last_grant;
    src_t              req_src;
    logic [ADDR_W-1:0] req_addr;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic [3:0]        wait_cnt;

    logic              i_req;
    logic              d_req;
    logic              any_req;
    logic              i_hit;
    logic              d_hit;
    logic              drain_now;
    logic              grant_d;
    logic [ADDR_W-1:0] grant_addr;
    logic              grant_hit;

    // IDLE decision terms: buffer line matches, drain trigger and round-robin winner
    always_comb begin
        i_req      = imem_read;
        d_req      = dmem_read | dmem_write;
        any_req    = i_req | d_req;
        i_hit      = wb_valid && (imem_address[ADDR_W-1:OFF] == wb_addr[ADDR_W-1:OFF]);
        d_hit      = wb_valid && (dmem_address[ADDR_W-1:OFF] == wb_addr[ADDR_W-1:OFF]);
        drain_now  = wb_valid && (!any_req || (dmem_write && !d_hit) ||
                                  (wait_cnt == 4'(MAX_WAIT)));
        grant_d    = (i_req && d_req) ? (last_grant == SRC_I) : d_req;
        grant_addr = grant_d ? dmem_address : imem_address;
        grant_hit  = grant_d ? d_hit : i_hit;
    end

    // Scheduler FSM with write-buffer, arbitration and wait-counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SRC_D;
            req_src    <= SRC_I;
            req_addr   <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (drain_now) begin
                        state <= DRAIN;
                    end else if (any_req) begin
                        last_grant <= grant_d ? SRC_D : SRC_I;
                        req_src    <= grant_d ? SRC_D : SRC_I;
                        req_addr   <= grant_addr;
                        if (wb_valid && (wait_cnt != 4'hF))
                            wait_cnt <= wait_cnt + 4'd1;
                        // A granted write only reaches here with the buffer empty
                        // or holding the same line, so loading always overwrites safely.
                        if (grant_d && dmem_write) begin
                            wb_valid <= 1'b1;
                            wb_addr  <= dmem_address;
                            wb_data  <= dmem_wdata;
                            state    <= DACK;
                        end else if (grant_hit) begin
                            state <= FWD;
                        end else begin
                            state <= grant_d ? DRD : IRD;
                        end
                    end
                end
                IRD, DRD: begin
                    if (bmem_resp)
                        state <= IDLE;
                end
                FWD, DACK: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (bmem_resp) begin
                        wb_valid <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Port outputs decoded from the registered state; read responses pass bmem through
    always_comb begin
        imem_resp    = 1'b0;
        imem_rdata   = '0;
        dmem_resp    = 1'b0;
        dmem_rdata   = '0;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_address = '0;
        bmem_wdata   = '0;
        case (state)
            IRD: begin
                bmem_read    = 1'b1;
                bmem_address = req_addr;
                if (bmem_resp) begin
                    imem_resp  = 1'b1;
                    imem_rdata = bmem_rdata;
                end
            end
            DRD: begin
                bmem_read    = 1'b1;
                bmem_address = req_addr;
                if (bmem_resp) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = bmem_rdata;
                end
            end
            FWD: begin
                if (req_src == SRC_I) begin
                    imem_resp  = 1'b1;
                    imem_rdata = wb_data;
                end else begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = wb_data;
                end
            end
            DACK: begin
                dmem_resp = 1'b1;
            end
            DRAIN: begin
                bmem_write   = 1'b1;
                bmem_address = wb_addr;
                bmem_wdata   = wb_data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_line_mem_scheduler.sv
// Bench for line_mem_scheduler: directed request streams push expected
// responses and memory operations into queues; a negedge monitor pops and compares.
module tb_line_mem_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  imem_address;
    logic         imem_read;
    logic [255:0] imem_rdata;
    logic         imem_resp;
    logic [31:0]  dmem_address;
    logic         dmem_read;
    logic         dmem_write;
    logic [255:0] dmem_wdata;
    logic [255:0] dmem_rdata;
    logic         dmem_resp;
    logic [31:0]  bmem_address;
    logic         bmem_read;
    logic         bmem_write;
    logic [255:0] bmem_wdata;
    logic [255:0] bmem_rdata;
    logic         bmem_resp;

    always #5 clk = ~clk;

    line_mem_scheduler #(
        .ADDR_W  (32),
        .LINE_W  (256),
        .MAX_WAIT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_address(imem_address),
        .imem_read   (imem_read),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .dmem_address(dmem_address),
        .dmem_read   (dmem_read),
        .dmem_write  (dmem_write),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_resp   (dmem_resp),
        .bmem_address(bmem_address),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_rdata  (bmem_rdata),
        .bmem_resp   (bmem_resp)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bmem_lat = 2;
    int busy     = 0;

    typedef struct {
        logic [255:0] data;
        bit           chk_data;
        int           lat;
        int           start;
        bit           via_bmem;
    } rsp_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           start;
    } bop_t;

    rsp_t iq[$];
    rsp_t dq[$];
    bop_t bq[$];

    localparam logic [255:0] DATA_A  = {8{32'h0A0A_0001}};
    localparam logic [255:0] DATA_A2 = {8{32'h0A0A_0002}};
    localparam logic [255:0] DATA_A3 = {8{32'h0A0A_0003}};
    localparam logic [255:0] DATA_C1 = {8{32'h0C0C_0001}};
    localparam logic [255:0] DATA_C2 = {8{32'h0C0C_0002}};
    localparam logic [255:0] DATA_E  = {8{32'h0E0E_0001}};
    localparam logic [255:0] DATA_F  = {8{32'h0F0F_0001}};

    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {8{a ^ 32'hA5A5_0000}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_b(input bit wr, input logic [31:0] a,
                                   input logic [255:0] d, input int st);
        bop_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.start = st;
        bq.push_back(e);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Burst memory model: answers after bmem_lat cycles of a held request
    initial begin
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bmem_resp) begin
                bmem_resp  = 1'b0;
                bmem_rdata = '0;
                busy       = 0;
            end else if (bmem_read || bmem_write) begin
                busy++;
                if (busy >= bmem_lat) begin
                    bmem_resp  = 1'b1;
                    bmem_rdata = bmem_read ? line_of(bmem_address) : '0;
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a response or memory op
    bit b_prev = 1'b0;
    always @(negedge clk) begin : mon
        rsp_t ie;
        rsp_t de;
        bop_t be;
        if (!imem_resp) check("imem_rdata_zero", imem_rdata, '0);
        if (!dmem_resp) check("dmem_rdata_zero", dmem_rdata, '0);
        if (!bmem_write) check("bmem_wdata_zero", bmem_wdata, '0);
        if (imem_resp) begin
            if (iq.size() == 0) begin
                checks++; failures++;
                $display("FAIL imem_unexpected_resp actual=1 required=0");
            end else begin
                ie = iq.pop_front();
                if (ie.chk_data) check("imem_rdata", imem_rdata, ie.data);
                if (ie.lat >= 0) check("imem_latency", 256'(cyc - ie.start + 1), 256'(ie.lat));
                check("imem_path", 256'(bmem_resp), 256'(ie.via_bmem));
            end
        end
        if (dmem_resp) begin
            if (dq.size() == 0) begin
                checks++; failures++;
                $display("FAIL dmem_unexpected_resp actual=1 required=0");
            end else begin
                de = dq.pop_front();
                if (de.chk_data) check("dmem_rdata", dmem_rdata, de.data);
                if (de.lat >= 0) check("dmem_latency", 256'(cyc - de.start + 1), 256'(de.lat));
                check("dmem_path", 256'(bmem_resp), 256'(de.via_bmem));
            end
        end
        if ((bmem_read || bmem_write) && !b_prev) begin
            if (bq.size() == 0) begin
                checks++; failures++;
                $display("FAIL bmem_unexpected_op actual=%0h required=none", bmem_address);
            end else begin
                be = bq.pop_front();
                check("bmem_is_write", 256'(bmem_write), 256'(be.wr));
                check("bmem_is_read", 256'(bmem_read), 256'(!be.wr));
                check("bmem_address", 256'(bmem_address), 256'(be.addr));
                if (be.wr) check("bmem_wdata", bmem_wdata, be.wdata);
                if (be.start >= 0) check("bmem_start_cycle", 256'(cyc), 256'(be.start));
            end
        end
        b_prev <= bmem_read || bmem_write;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset for one edge, then confirm every control output is quiet the next cycle
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 256'({imem_resp, dmem_resp, bmem_read, bmem_write}), '0);
        check("reset_bmem_address", 256'(bmem_address), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic i_issue(input logic [31:0] a, input logic [255:0] d, input int lat);
        rsp_t e;
        bit   got;
        e.data = d; e.chk_data = 1'b1; e.lat = lat; e.start = cyc; e.via_bmem = 1'b1;
        iq.push_back(e);
        imem_address = a;
        imem_read    = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (imem_resp) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL imem_timeout actual=no_resp required=resp addr=%0h", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic i_drop();
        imem_read    = 1'b0;
        imem_address = '0;
    endtask

    task automatic d_issue(input bit we, input logic [31:0] a, input logic [255:0] wd,
                           input logic [255:0] rd, input int lat, input bit via);
        rsp_t e;
        bit   got;
        e.data = rd; e.chk_data = !we; e.lat = lat; e.start = cyc; e.via_bmem = via;
        dq.push_back(e);
        dmem_address = a;
        dmem_read    = !we;
        dmem_write   = we;
        dmem_wdata   = wd;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (dmem_resp) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL dmem_timeout actual=no_resp required=resp addr=%0h", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic d_drop();
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = '0;
        dmem_wdata   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        i_drop();
        d_drop();
        idle(2);
        do_reset();

        // T1: single I read, memory answers after 5 cycles
        bmem_lat = 5;
        push_b(1'b0, 32'h100, '0, cyc + 1);
        i_issue(32'h100, line_of(32'h100), 6);
        i_drop();
        idle(4);

        // T2: simultaneous I and D reads alternate, I first after reset
        bmem_lat = 2;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            push_b(1'b0, 32'h1000 + 32'(r) * 32'h20, '0, -1);
            push_b(1'b0, 32'h2000 + 32'(r) * 32'h20, '0, -1);
        end
        fork
            begin
                for (int r = 0; r < 4; r++)
                    i_issue(32'h1000 + 32'(r) * 32'h20, line_of(32'h1000 + 32'(r) * 32'h20), -1);
                i_drop();
            end
            begin
                for (int r = 0; r < 4; r++)
                    d_issue(1'b0, 32'h2000 + 32'(r) * 32'h20, '0,
                            line_of(32'h2000 + 32'(r) * 32'h20), -1, 1'b1);
                d_drop();
            end
        join
        idle(4);

        // T3: posted write acknowledged in 2 cycles, drained once idle
        push_b(1'b1, 32'h200, DATA_A, cyc + 3);
        d_issue(1'b1, 32'h200, DATA_A, '0, 2, 1'b0);
        d_drop();
        idle(6);

        // T4: read of buffered line forwards; adjacent line goes to memory
        push_b(1'b0, 32'h220, '0, -1);
        push_b(1'b1, 32'h200, DATA_A2, -1);
        fork
            begin
                d_issue(1'b1, 32'h200, DATA_A2, '0, 2, 1'b0);
                d_issue(1'b0, 32'h200, '0, DATA_A2, 2, 1'b0);
                d_drop();
            end
            begin
                idle(3);
                i_issue(32'h220, line_of(32'h220), 4);
                i_drop();
            end
        join
        idle(6);

        // T5: write to another line drains first; same-line write overwrites
        push_b(1'b1, 32'h200, DATA_A3, -1);
        push_b(1'b1, 32'h300, DATA_C2, -1);
        d_issue(1'b1, 32'h200, DATA_A3, '0, 2, 1'b0);
        d_issue(1'b1, 32'h300, DATA_C1, '0, 5, 1'b0);
        d_issue(1'b1, 32'h300, DATA_C2, '0, 2, 1'b0);
        d_drop();
        idle(8);

        // T6: four grants with a full buffer force a drain under continuous I reads
        for (int r = 0; r < 4; r++)
            push_b(1'b0, 32'h500 + 32'(r) * 32'h20, '0, -1);
        push_b(1'b1, 32'h400, DATA_E, -1);
        push_b(1'b0, 32'h580, '0, -1);
        fork
            begin
                d_issue(1'b1, 32'h400, DATA_E, '0, 2, 1'b0);
                d_drop();
            end
            begin
                idle(1);
                for (int r = 0; r < 4; r++)
                    i_issue(32'h500 + 32'(r) * 32'h20, line_of(32'h500 + 32'(r) * 32'h20), -1);
                i_issue(32'h580, line_of(32'h580), 6);
                i_drop();
            end
        join
        idle(4);

        // Reset during a drain: write drops and the buffered line is discarded
        bmem_lat = 20;
        push_b(1'b1, 32'h600, DATA_F, cyc + 3);
        d_issue(1'b1, 32'h600, DATA_F, '0, 2, 1'b0);
        d_drop();
        idle(2);
        do_reset();
        bmem_lat = 2;
        idle(10);

        check("imem_queue_drained", 256'(iq.size()), '0);
        check("dmem_queue_drained", 256'(dq.size()), '0);
        check("bmem_queue_drained", 256'(bq.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
